mem_port_arbiter: RTL and testbench

//  Shares the single processor-memory bus between the instruction-fetch miss path (IC) and the LSQ.

---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Processor-memory bus bundle shared by the IC miss path, the LSQ, memory and the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);

  // Requester side
  logic [1:0]        ic2arb_command;
  logic [ADDR_W-1:0] ic2arb_addr;
  logic [1:0]        lsq2arb_command;
  logic [ADDR_W-1:0] lsq2arb_addr;
  logic [DATA_W-1:0] lsq2arb_data;

  // Memory side
  logic [1:0]        arb2mem_command;
  logic [ADDR_W-1:0] arb2mem_addr;
  logic [DATA_W-1:0] arb2mem_data;
  logic [TAG_W-1:0]  mem2arb_response;
  logic [TAG_W-1:0]  mem2arb_tag;
  logic [DATA_W-1:0] mem2arb_data;

  // Responses and returning data
  logic [TAG_W-1:0]  arb2ic_response;
  logic [TAG_W-1:0]  arb2lsq_response;
  logic              arb2ic_valid;
  logic              arb2lsq_valid;
  logic [TAG_W-1:0]  arb2req_tag;
  logic [DATA_W-1:0] arb2req_data;

  // Status
  logic [2:0]        ic_cnt;
  logic [3:0]        lsq_cnt;
  logic              err_stray;

  // Arbiter view
  modport slave (
    input  ic2arb_command, ic2arb_addr,
    input  lsq2arb_command, lsq2arb_addr, lsq2arb_data,
    input  mem2arb_response, mem2arb_tag, mem2arb_data,
    output arb2mem_command, arb2mem_addr, arb2mem_data,
    output arb2ic_response, arb2lsq_response,
    output arb2ic_valid, arb2lsq_valid, arb2req_tag, arb2req_data,
    output ic_cnt, lsq_cnt, err_stray
  );

  // Environment view (requesters plus memory)
  modport master (
    output ic2arb_command, ic2arb_addr,
    output lsq2arb_command, lsq2arb_addr, lsq2arb_data,
    output mem2arb_response, mem2arb_tag, mem2arb_data,
    input  arb2mem_command, arb2mem_addr, arb2mem_data,
    input  arb2ic_response, arb2lsq_response,
    input  arb2ic_valid, arb2lsq_valid, arb2req_tag, arb2req_data,
    input  ic_cnt, lsq_cnt, err_stray
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the IC miss path and the LSQ: zero-latency
// round-robin grant, ticket ownership tracking, return routing and load credits.
module mem_port_arbiter #(
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned NUM_TAGS    = 15,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MAX_OUT_IC  = 4,
  parameter int unsigned MAX_OUT_LSQ = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_port_arbiter_if.slave     bus
);

  localparam int unsigned TBL_N     = NUM_TAGS + 1;  // entry 0 is never written
  localparam int unsigned IC_CNT_W  = 3;
  localparam int unsigned LSQ_CNT_W = 4;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [TBL_N-1:0]     owner_vld_q, owner_vld_d;
  logic [TBL_N-1:0]     owner_q, owner_d;          // 0 = IC, 1 = LSQ
  logic                 rr_q, rr_d;                // 0 = IC has priority
  logic [IC_CNT_W-1:0]  ic_cnt_q, ic_cnt_d;
  logic [LSQ_CNT_W-1:0] lsq_cnt_q, lsq_cnt_d;
  logic                 err_stray_q, err_stray_d;

  logic ic_elig, lsq_elig, gnt_ic, gnt_lsq, accept, acc_load;
  logic ret_vld, ret_hit, ret_lsq;

  // Eligibility, grant and return decode; everything is held quiet while in reset
  always_comb begin
    ic_elig  = reset_n && (bus.ic2arb_command == BUS_LOAD)
               && (ic_cnt_q < IC_CNT_W'(MAX_OUT_IC));
    lsq_elig = reset_n && ((bus.lsq2arb_command == BUS_STORE)
               || ((bus.lsq2arb_command == BUS_LOAD)
                   && (lsq_cnt_q < LSQ_CNT_W'(MAX_OUT_LSQ))));
    gnt_ic   = ic_elig && (!lsq_elig || !rr_q);
    gnt_lsq  = lsq_elig && (!ic_elig || rr_q);
    accept   = (gnt_ic || gnt_lsq) && (bus.mem2arb_response != '0);
    acc_load = accept && (gnt_ic || (bus.lsq2arb_command == BUS_LOAD));
    ret_vld  = reset_n && (bus.mem2arb_tag != '0);
    ret_hit  = ret_vld && owner_vld_q[bus.mem2arb_tag];
    ret_lsq  = owner_q[bus.mem2arb_tag];
  end

  // Combinational bus forwarding and response/return routing
  always_comb begin
    bus.arb2mem_command  = BUS_NONE;
    bus.arb2mem_addr     = '0;
    bus.arb2mem_data     = '0;
    bus.arb2ic_response  = '0;
    bus.arb2lsq_response = '0;
    if (gnt_ic) begin
      bus.arb2mem_command = bus.ic2arb_command;
      bus.arb2mem_addr    = bus.ic2arb_addr;
      bus.arb2ic_response = bus.mem2arb_response;
    end else if (gnt_lsq) begin
      bus.arb2mem_command  = bus.lsq2arb_command;
      bus.arb2mem_addr     = bus.lsq2arb_addr;
      bus.arb2mem_data     = bus.lsq2arb_data;
      bus.arb2lsq_response = bus.mem2arb_response;
    end
    bus.arb2ic_valid  = ret_hit && !ret_lsq;
    bus.arb2lsq_valid = ret_hit && ret_lsq;
    bus.arb2req_tag   = reset_n ? bus.mem2arb_tag  : '0;
    bus.arb2req_data  = reset_n ? bus.mem2arb_data : '0;
    bus.ic_cnt        = ic_cnt_q;
    bus.lsq_cnt       = lsq_cnt_q;
    bus.err_stray     = err_stray_q;
  end

  // Next state: retire on return first so a same-tag accept leaves the new owner valid
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    ic_cnt_d    = ic_cnt_q;
    lsq_cnt_d   = lsq_cnt_q;
    err_stray_d = err_stray_q || (ret_vld && !ret_hit);

    if (ret_hit) owner_vld_d[bus.mem2arb_tag] = 1'b0;
    if (acc_load) begin
      owner_vld_d[bus.mem2arb_response] = 1'b1;
      owner_d[bus.mem2arb_response]     = gnt_lsq;
    end
    if (accept) rr_d = gnt_ic;

    unique case ({acc_load && gnt_ic, ret_hit && !ret_lsq})
      2'b10:   ic_cnt_d = ic_cnt_q + IC_CNT_W'(1);
      2'b01:   ic_cnt_d = ic_cnt_q - IC_CNT_W'(1);
      default: ic_cnt_d = ic_cnt_q;
    endcase
    unique case ({acc_load && gnt_lsq, ret_hit && ret_lsq})
      2'b10:   lsq_cnt_d = lsq_cnt_q + LSQ_CNT_W'(1);
      2'b01:   lsq_cnt_d = lsq_cnt_q - LSQ_CNT_W'(1);
      default: lsq_cnt_d = lsq_cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_vld_q <= '0;
      owner_q     <= '0;
      rr_q        <= 1'b0;
      ic_cnt_q    <= '0;
      lsq_cnt_q   <= '0;
      err_stray_q <= 1'b0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      ic_cnt_q    <= ic_cnt_d;
      lsq_cnt_q   <= lsq_cnt_d;
      err_stray_q <= err_stray_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: the driver queues hand-computed
// expectations per cycle, the monitor compares them at the falling edge.
module tb_mem_port_arbiter;

  localparam logic [1:0]  N  = 2'd0;
  localparam logic [1:0]  L  = 2'd1;
  localparam logic [1:0]  ST = 2'd2;
  localparam logic [63:0] IC_A  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] LSQ_A = 64'h0000_0000_0000_2000;
  localparam logic [63:0] LSQ_D = 64'h0000_0000_0000_CAFE;

  typedef struct packed {
    logic        rst_n;
    logic [1:0]  icc;
    logic [1:0]  lc;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] md;
  } stim_t;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  ic_r;
    logic [3:0]  lsq_r;
    logic        ic_v;
    logic        lsq_v;
    logic [3:0]  tag;
    logic [63:0] rdata;
    logic [2:0]  ic_cnt;
    logic [3:0]  lsq_cnt;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  mem_port_arbiter_if #(.TAG_W(4), .ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(
    .TAG_W(4), .NUM_TAGS(15), .ADDR_W(64), .DATA_W(64),
    .MAX_OUT_IC(4), .MAX_OUT_LSQ(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(input int rst, input logic [1:0] icc, input logic [1:0] lc,
                              input int resp, input int tag, input logic [63:0] md);
    stim_t s;
    s.rst_n = (rst != 0);
    s.icc   = icc;
    s.lc    = lc;
    s.resp  = 4'(resp);
    s.tag   = 4'(tag);
    s.md    = md;
    return s;
  endfunction

  // gsel: 0 none, 1 IC load, 2 LSQ store, 3 LSQ load on the memory bus
  function automatic exp_t E(input int gsel, input int ic_r, input int lsq_r,
                             input int ic_v, input int lsq_v, input int tag,
                             input logic [63:0] rdata, input int ic_cnt,
                             input int lsq_cnt, input int err);
    exp_t e;
    e = '0;
    case (gsel)
      1: begin e.cmd = L;  e.addr = IC_A; end
      2: begin e.cmd = ST; e.addr = LSQ_A; e.data = LSQ_D; end
      3: begin e.cmd = L;  e.addr = LSQ_A; e.data = LSQ_D; end
      default: ;
    endcase
    e.ic_r    = 4'(ic_r);
    e.lsq_r   = 4'(lsq_r);
    e.ic_v    = (ic_v != 0);
    e.lsq_v   = (lsq_v != 0);
    e.tag     = 4'(tag);
    e.rdata   = rdata;
    e.ic_cnt  = 3'(ic_cnt);
    e.lsq_cnt = 4'(lsq_cnt);
    e.err     = (err != 0);
    return e;
  endfunction

  // Apply one cycle of stimulus just after the rising edge and queue its expectation
  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    reset_n              = s.rst_n;
    bus.ic2arb_command   = s.icc;
    bus.ic2arb_addr      = IC_A;
    bus.lsq2arb_command  = s.lc;
    bus.lsq2arb_addr     = LSQ_A;
    bus.lsq2arb_data     = LSQ_D;
    bus.mem2arb_response = s.resp;
    bus.mem2arb_tag      = s.tag;
    bus.mem2arb_data     = s.md;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int cyc, input logic [63:0] act,
                     input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, cyc, act, expv);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared at the falling edge
  int vec = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("arb2mem_command",  vec, 64'(bus.arb2mem_command),  64'(e.cmd));
      chk("arb2mem_addr",     vec, bus.arb2mem_addr,          e.addr);
      chk("arb2mem_data",     vec, bus.arb2mem_data,          e.data);
      chk("arb2ic_response",  vec, 64'(bus.arb2ic_response),  64'(e.ic_r));
      chk("arb2lsq_response", vec, 64'(bus.arb2lsq_response), 64'(e.lsq_r));
      chk("arb2ic_valid",     vec, 64'(bus.arb2ic_valid),      64'(e.ic_v));
      chk("arb2lsq_valid",    vec, 64'(bus.arb2lsq_valid),     64'(e.lsq_v));
      chk("arb2req_tag",      vec, 64'(bus.arb2req_tag),       64'(e.tag));
      chk("arb2req_data",     vec, bus.arb2req_data,          e.rdata);
      chk("ic_cnt",           vec, 64'(bus.ic_cnt),            64'(e.ic_cnt));
      chk("lsq_cnt",          vec, 64'(bus.lsq_cnt),           64'(e.lsq_cnt));
      chk("err_stray",        vec, 64'(bus.err_stray),         64'(e.err));
      vec++;
    end
  end

  initial begin
    bus.ic2arb_command   = N;
    bus.ic2arb_addr      = '0;
    bus.lsq2arb_command  = N;
    bus.lsq2arb_addr     = '0;
    bus.lsq2arb_data     = '0;
    bus.mem2arb_response = '0;
    bus.mem2arb_tag      = '0;
    bus.mem2arb_data     = '0;
    repeat (2) @(posedge clk);

    // Out of reset, idle
    step(S(1, N, N, 0, 0, 0), E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // IC load alone, ticket 3; then an LSQ store hands priority back to IC; tag 3 returns
    step(S(1, L, N, 3, 0, 0),        E(1, 3, 0, 0, 0, 0, 0,        0, 0, 0));
    step(S(1, N, ST, 1, 0, 0),       E(2, 0, 1, 0, 0, 0, 0,        1, 0, 0));
    step(S(1, N, N, 0, 3, 64'h33),   E(0, 0, 0, 1, 0, 3, 64'h33,   1, 0, 0));
    // Both request, IC first, then LSQ store; store leaves lsq_cnt alone
    step(S(1, L, ST, 5, 0, 0),       E(1, 5, 0, 0, 0, 0, 0,        0, 0, 0));
    step(S(1, L, ST, 6, 0, 0),       E(2, 0, 6, 0, 0, 0, 0,        1, 0, 0));
    step(S(1, N, N, 0, 0, 0),        E(0, 0, 0, 0, 0, 0, 0,        1, 0, 0));
    // Rejected grants keep priority on IC
    step(S(1, L, L, 0, 0, 0),        E(1, 0, 0, 0, 0, 0, 0,        1, 0, 0));
    step(S(1, L, L, 0, 0, 0),        E(1, 0, 0, 0, 0, 0, 0,        1, 0, 0));
    step(S(1, L, L, 0, 0, 0),        E(1, 0, 0, 0, 0, 0, 0,        1, 0, 0));
    step(S(1, L, L, 8, 0, 0),        E(1, 8, 0, 0, 0, 0, 0,        1, 0, 0));
    step(S(1, L, L, 2, 0, 0),        E(3, 0, 2, 0, 0, 0, 0,        2, 0, 0));
    // IC load tag 7 returns 0xDEAD to IC; LSQ tag 2 returns to LSQ
    step(S(1, L, N, 7, 0, 0),        E(1, 7, 0, 0, 0, 0, 0,        2, 1, 0));
    step(S(1, N, N, 0, 7, 64'hDEAD), E(0, 0, 0, 1, 0, 7, 64'hDEAD, 3, 1, 0));
    step(S(1, N, N, 0, 2, 64'hBEEF), E(0, 0, 0, 0, 1, 2, 64'hBEEF, 2, 1, 0));
    // Fill IC credits to 4; a further IC load is not forwarded until a return lands
    step(S(1, L, N, 10, 0, 0),       E(1, 10, 0, 0, 0, 0, 0,       2, 0, 0));
    step(S(1, L, N, 11, 0, 0),       E(1, 11, 0, 0, 0, 0, 0,       3, 0, 0));
    step(S(1, L, N, 12, 0, 0),       E(0, 0, 0, 0, 0, 0, 0,        4, 0, 0));
    step(S(1, L, N, 12, 5, 64'h55),  E(0, 0, 0, 1, 0, 5, 64'h55,   4, 0, 0));
    step(S(1, L, N, 12, 0, 0),       E(1, 12, 0, 0, 0, 0, 0,       3, 0, 0));
    step(S(1, N, N, 0, 8, 64'h88),   E(0, 0, 0, 1, 0, 8, 64'h88,   4, 0, 0));
    // Accept and return on IC in one cycle: net count unchanged
    step(S(1, L, N, 13, 10, 64'hAA), E(1, 13, 0, 1, 0, 10, 64'hAA, 3, 0, 0));
    // LSQ reuses tag 11 while its IC data returns: old owner gets data, new owner kept
    step(S(1, N, L, 11, 11, 64'h11),   E(3, 0, 11, 1, 0, 11, 64'h11,   3, 0, 0));
    step(S(1, N, N, 0, 11, 64'h1111),  E(0, 0, 0, 0, 1, 11, 64'h1111, 2, 1, 0));
    // Stray tag 9 sets the sticky error
    step(S(1, N, N, 0, 9, 64'h99),   E(0, 0, 0, 0, 0, 9, 64'h99,   2, 0, 0));
    step(S(1, N, N, 0, 0, 0),        E(0, 0, 0, 0, 0, 0, 0,        2, 0, 1));
    // Reset mid-traffic silences everything at once
    step(S(0, L, ST, 4, 12, 64'hCC), E(0, 0, 0, 0, 0, 0, 0,        0, 0, 0));
    step(S(1, N, N, 0, 0, 0),        E(0, 0, 0, 0, 0, 0, 0,        0, 0, 0));
    // Pre-reset tag 12 is now untracked
    step(S(1, N, N, 0, 12, 64'hCC),  E(0, 0, 0, 0, 0, 12, 64'hCC,  0, 0, 0));
    step(S(1, N, N, 0, 0, 0),        E(0, 0, 0, 0, 0, 0, 0,        0, 0, 1));

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
